bcd_counter_2d: RTL
===================

Name: bcd_counter_2d

Overview:
- Two-digit (00–99) synchronous BCD up/down counter with parallel load.
- Sits directly upstream of the team's BCD-to-Gray converter.
- Each digit output drives a converter's 4-bit BCD input; `bcd_vld` drives the converter's enable.
- Guarantees the converter only ever sees legal BCD codes (0–9) while enabled.

Parameters:
- WRAP, 1, 1 = roll over 99↔00; 0 = saturate at 99 (up) / 00 (down).
- STEP, 1, increment/decrement size per enabled cycle; legal range 1–9; applied with full decimal carry/borrow across digits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable, sampled on the clk rising edge.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load request; has priority over en.
- load_val  input  8  [7:4] tens digit, [3:0] ones digit.
- bcd_ones  output  4  ones digit; feeds the Gray converter bcd input.
- bcd_tens  output  4  tens digit; feeds the second Gray converter.
- bcd_vld  output  1  drives converter en; high when the digits are valid.
- tc  output  1  terminal-count pulse.
- load_err  output  1  pulse: load rejected because of a non-BCD digit.

Behaviour:
- **Reset.** While rst_n = 0, asynchronously: bcd_ones = 0, bcd_tens = 0, bcd_vld = 0, tc = 0, load_err = 0.
- **Validity.** bcd_vld goes 1 on the first rising clk edge after rst_n deasserts, then stays 1 until the next reset.
  - Mid-operation reset drops every output immediately, including bcd_vld.
- **Registered outputs.** All outputs are registered. A change takes effect on the same edge that samples the control, so latency is 1 clock from input to output.
- **Priority per edge:** load > en > hold.
- **Load.**
  - If both load_val nibbles are ≤ 9, the digits take load_val on the edge; tc = 0 and load_err = 0.
  - If either nibble is > 9, the digits hold, load_err = 1 for exactly that one cycle, and tc = 0.
  - en is ignored whenever load = 1.
- **Count up** (en = 1, load = 0, up_dn = 1). New value = (tens*10 + ones + STEP) with decimal carry.
  - If the sum is > 99 and WRAP = 1: value = sum − 100 and tc = 1 for one cycle.
  - If the sum is > 99 and WRAP = 0: value = 99, and tc = 1 for one cycle on every such attempted overflow edge, including while already at 99.
- **Count down** (up_dn = 0). New value = (tens*10 + ones − STEP) with decimal borrow.
  - If the result is < 0 and WRAP = 1: value = result + 100 and tc = 1.
  - If the result is < 0 and WRAP = 0: value = 00 and tc = 1.
- **tc in other cases.** tc = 0 on every edge not described above, including hold and load.
- **Ones-digit arithmetic.**
  - Compute with a 5-bit intermediate.
  - Up: if sum > 9, subtract 10 and carry 1 into the tens digit.
  - Down: if result < 0, add 10 and borrow 1 from the tens digit.
- **Tens digit.** Uses the same rules. Its carry out or borrow out is the overflow condition above.
- **Output invariant.** bcd_ones and bcd_tens never hold values 10–15 in any cycle, whatever the input sequence.
- **up_dn changes.** up_dn may change on any cycle; only the value sampled on the edge matters.
- **Control FSM** (2 states, drives bcd_vld):
  - RST: entered asynchronously on rst_n = 0; bcd_vld = 0.
  - RUN: entered on the first clk edge with rst_n = 1; bcd_vld = 1; no exit except reset.
  - Count, load and load_err behave identically in the first RUN edge, i.e. a load on the first edge after reset is honoured.

Test Plan:
- Reset, then en = 1, up_dn = 1, STEP = 1, WRAP = 1 for 100 cycles → digits 00,01,…,09,10,…,99,00. tc high only on the 99→00 edge. Converter output for ones digit 9 = 4'b1101.
- Load 8'h37 → next cycle tens = 3, ones = 7. Load 8'h3A → digits hold at 37 and load_err = 1 for one cycle. Load 8'hF0 → same rejection.
- WRAP = 0, load 8'h98, STEP = 1, count up 3 cycles → 99, 99, 99. tc = 0, 1, 1.
  - Then down 2 cycles → 98, 97 with tc = 0.
- WRAP = 1, STEP = 7, load 8'h05, count down → 98 with tc = 1. Count up → 05 with tc = 1.
- load = 1 and en = 1 on the same edge with load_val = 8'h42 → 42; no step applied and tc = 0.
- Assert rst_n low mid-count at value 63, asynchronously between edges → all outputs 0 immediately. On release, bcd_vld = 0 until the first edge, then 1, and counting resumes from 00.

Source files
------------

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter (00-99) with parallel load, feeding BCD-to-Gray converters.
// Ports: clk, rst_n, en, up_dn, load, load_val[7:0] -> bcd_ones, bcd_tens, bcd_vld, tc, load_err.
module bcd_counter_2d #(
  parameter bit          WRAP = 1'b1,
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       bcd_vld,
  output logic       tc,
  output logic       load_err
);

  localparam logic [4:0] STEP5 = 5'(STEP);

  typedef enum logic {
    RST = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t state;

  logic [4:0] o_up;
  logic [4:0] t_up;
  logic [4:0] o_dn;
  logic [4:0] t_dn;
  logic       c_up;
  logic       b_dn;
  logic       ovf;
  logic       unf;
  logic [3:0] ou_n;
  logic [3:0] tu_n;
  logic [3:0] od_n;
  logic [3:0] td_n;
  logic       load_ok;

  logic [3:0] nxt_ones;
  logic [3:0] nxt_tens;
  logic       nxt_tc;
  logic       nxt_err;

  // Up path: ones digit absorbs STEP, any excess carries into tens.
  always_comb begin
    o_up = {1'b0, bcd_ones} + STEP5;
    c_up = (o_up > 5'd9);
    ou_n = c_up ? 4'(o_up - 5'd10) : o_up[3:0];
    t_up = {1'b0, bcd_tens} + {4'd0, c_up};
    ovf  = (t_up > 5'd9);
    tu_n = ovf ? 4'(t_up - 5'd10) : t_up[3:0];
  end

  // Down path: bit 4 of the 5-bit difference flags a negative result.
  always_comb begin
    o_dn = {1'b0, bcd_ones} - STEP5;
    b_dn = o_dn[4];
    od_n = b_dn ? 4'(o_dn + 5'd10) : o_dn[3:0];
    t_dn = {1'b0, bcd_tens} - {4'd0, b_dn};
    unf  = t_dn[4];
    td_n = unf ? 4'(t_dn + 5'd10) : t_dn[3:0];
  end

  assign load_ok = (load_val[7:4] <= 4'd9) &&
                   (load_val[3:0] <= 4'd9);

  always_comb begin
    nxt_ones = bcd_ones;
    nxt_tens = bcd_tens;
    nxt_tc   = 1'b0;
    nxt_err  = 1'b0;
    unique case (1'b1)
      load: begin
        if (load_ok) begin
          nxt_ones = load_val[3:0];
          nxt_tens = load_val[7:4];
        end else begin
          nxt_err = 1'b1;
        end
      end
      (!load && en && up_dn): begin
        nxt_tc = ovf;
        if (ovf && !WRAP) begin
          nxt_ones = 4'd9;
          nxt_tens = 4'd9;
        end else begin
          nxt_ones = ou_n;
          nxt_tens = tu_n;
        end
      end
      (!load && en && !up_dn): begin
        nxt_tc = unf;
        if (unf && !WRAP) begin
          nxt_ones = 4'd0;
          nxt_tens = 4'd0;
        end else begin
          nxt_ones = od_n;
          nxt_tens = td_n;
        end
      end
      (!load && !en): begin
        nxt_ones = bcd_ones;
        nxt_tens = bcd_tens;
      end
      default: begin
        nxt_ones = bcd_ones;
        nxt_tens = bcd_tens;
      end
    endcase
  end

  // The first edge out of reset already acts on load/en,
  // so the data path does not wait on the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST;
      bcd_vld  <= 1'b0;
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= RUN;
      bcd_vld  <= 1'b1;
      bcd_ones <= nxt_ones;
      bcd_tens <= nxt_tens;
      tc       <= nxt_tc;
      load_err <= nxt_err;
    end
  end

endmodule
